soc_cpu_1_mulx_seq: RTL and testbench

SOC_CPU_1_MULX_SEQ -- requirements
Module: soc_cpu_1_mulx_seq

---
 rtl/soc_cpu_1_mulx_seq.sv | 102 ++++++++++
 tb/tb_soc_cpu_1_mulx_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/soc_cpu_1_mulx_seq.sv
// rtl/soc_cpu_1_mulx_seq.sv - sequential 32x32->64 multiplier built from four 16x16 partial products
// Signed modes are handled by an unsigned product plus a high-word correction in FIXUP.
module soc_cpu_1_mulx_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        ready,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIXUP} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [63:0] acc_q;
  logic [1:0]  idx_q;
  logic [31:0] pp_q;
  logic [5:0]  pp_shift_q;
  logic        pp_valid_q;
  logic        done_q;
  logic        accept;
  logic [15:0] mul_a, mul_b;
  logic [5:0]  issue_shift;
  logic        sub_b, sub_a;
  logic [31:0] fix_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = ISSUE;
      end
      ISSUE: if (idx_q == 2'd3) state_d = DRAIN;
      DRAIN: state_d = FIXUP;
      FIXUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = start && ready;

  // idx bit0 picks the high half of a, bit1 the high half of b
  assign mul_a       = idx_q[0] ? a_q[31:16] : a_q[15:0];
  assign mul_b       = idx_q[1] ? b_q[31:16] : b_q[15:0];
  assign issue_shift = {idx_q[1] & idx_q[0], idx_q[1] ^ idx_q[0], 4'b0000};

  // Two's-complement correction of the unsigned product's upper word
  assign sub_b  = ((op_q == 2'b01) || (op_q == 2'b10)) && a_q[31];
  assign sub_a  = (op_q == 2'b10) && b_q[31];
  assign fix_hi = acc_q[63:32] - (sub_b ? b_q : 32'd0) - (sub_a ? a_q : 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 2'b00;
      acc_q      <= 64'd0;
      idx_q      <= 2'd0;
      pp_q       <= 32'd0;
      pp_shift_q <= 6'd0;
      pp_valid_q <= 1'b0;
      done_q     <= 1'b0;
      result     <= 64'd0;
    end else begin
      done_q     <= 1'b0;
      pp_valid_q <= (state_q == ISSUE);
      if (accept) begin
        a_q   <= src1;
        b_q   <= src2;
        op_q  <= op;
        acc_q <= 64'd0;
        idx_q <= 2'd0;
      end
      if (state_q == ISSUE) begin
        pp_q       <= {16'd0, mul_a} * {16'd0, mul_b};
        pp_shift_q <= issue_shift;
        if (idx_q != 2'd3) idx_q <= idx_q + 2'd1;
      end
      if (pp_valid_q) acc_q <= acc_q + ({32'd0, pp_q} << pp_shift_q);
      if (state_q == FIXUP) begin
        acc_q[63:32] <= fix_hi;
        result       <= {fix_hi, acc_q[31:0]};
        done_q       <= 1'b1;
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_soc_cpu_1_mulx_seq.sv
// tb/tb_soc_cpu_1_mulx_seq.sv - directed self-checking bench for soc_cpu_1_mulx_seq
module tb_soc_cpu_1_mulx_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        ready, done;
  logic [63:0] result;

  int n_cmp;
  int n_bad;

  soc_cpu_1_mulx_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src1(src1), .src2(src2), .ready(ready), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request at a negedge, scrambles inputs after acceptance, checks latency and result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; src1 = ~a; src2 = b ^ 32'h5A5A_A5A5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {62'd0, ready, done}, 64'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {62'd0, ready, done}, 64'd3);
    chk({tag, "_result"}, result, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, {62'd0, ready, done}, 64'd2);
    chk({tag, "_hold"}, result, exp);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; src1 = 32'd0; src2 = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_flags", {62'd0, ready, done}, 64'd2);
    chk("reset_result", result, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("uu_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("ss_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op("su_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    run_op("uu_shift", 2'b00, 32'h0001_2345, 32'h0001_0000, 64'h0000_0001_2345_0000);
    run_op("op11_uns", 2'b11, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
    run_op("ss_minmin", 2'b10, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("su_neg1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);

    // Back-to-back with start held high; second operand set is applied right after acceptance
    start = 1'b1; op = 2'b00; src1 = 32'd3; src2 = 32'd5;
    @(posedge clk);
    #1;
    op = 2'b10; src1 = 32'hFFFF_FFFE; src2 = 32'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 7) begin
        chk("b2b_done1", {62'd0, ready, done}, 64'd3);
        chk("b2b_res1", result, 64'd15);
      end else if (k == 14) begin
        chk("b2b_done2", {62'd0, ready, done}, 64'd3);
        chk("b2b_res2", result, 64'hFFFF_FFFF_FFFF_FFFA);
        start = 1'b0;
      end else begin
        chk("b2b_busy", {62'd0, ready, done}, 64'd0);
        if (k == 8) chk("b2b_hold1", result, 64'd15);
      end
    end
    @(negedge clk);
    chk("b2b_idle", {62'd0, ready, done}, 64'd2);

    // Reset in the middle of an operation
    start = 1'b1; op = 2'b00; src1 = 32'h1234_5678; src2 = 32'h0000_0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_flags", {62'd0, ready, done}, 64'd2);
    chk("rst_mid_result", result, 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_hold_flags", {62'd0, ready, done}, 64'd2);
    end
    reset_n = 1'b1;
    run_op("after_rst", 2'b00, 32'h0001_2345, 32'h0001_0000, 64'h0000_0001_2345_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
